// File: rtl/gate_equiv_sweeper.sv
// gate_equiv_sweeper
//   Sequential equivalence engine for an N-input logic gate. On an accepted
//   start it walks every input minterm 0..2^N-1, one per clock, and for each
//   one evaluates two forms of the selected gate:
//     - the expression (De Morgan) form, reported as ref_bit;
//     - a structural form built only from 2-input NANDs chained over the
//       inputs, reported as gate_bit. An optional fault can invert it at a
//       chosen minterm.
//   It compares the two forms, builds the truth table of the expression form,
//   and counts the minterms where the forms disagree.
//
// Parameters
//   N          number of gate inputs (legal 2..6)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset, priority over everything
//   start      sweep request, sampled only while idle
//   op         0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR (6,7 illegal)
//   fault_en   invert the structural result at fault_idx
//   fault_idx  minterm at which the fault is injected
//   busy       sweep in progress, including the done cycle
//   valid      minterm/vec/ref_bit/gate_bit hold a minterm result
//   minterm    index of the presented minterm
//   vec        applied input vector (equals minterm), MSB = input N-1
//   ref_bit    expression-form result
//   gate_bit   NAND-only structural result after fault injection
//   tt         truth table of ref_bit, bit m = result at minterm m
//   mism_cnt   number of mismatching minterms in the last/current sweep
//   done       one-cycle pulse when the sweep finishes
//   pass       mism_cnt == 0, valid from done until the next accepted start
//   err        one-cycle pulse for a start with an illegal op
//
// All outputs are registered. A sweep accepted at edge k presents minterm 0
// in cycle k+1 together with its truth-table bit and mismatch count.

module gate_equiv_sweeper #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic           fault_en,
  input  logic [N-1:0]   fault_idx,
  output logic           busy,
  output logic           valid,
  output logic [N-1:0]   minterm,
  output logic [N-1:0]   vec,
  output logic           ref_bit,
  output logic           gate_bit,
  output logic [2**N-1:0] tt,
  output logic [N:0]     mism_cnt,
  output logic           done,
  output logic           pass,
  output logic           err
);

  localparam int TW = 2**N;
  localparam logic [N-1:0] LAST_M = N'(TW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Gate evaluation
  // ---------------------------------------------------------------------------
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // Expression form, written with De Morgan identities over the inverted inputs.
  function automatic logic ref_eval(input logic [2:0] f, input logic [N-1:0] v);
    case (f)
      3'd0:    return |(~v);
      3'd1:    return &(~v);
      3'd2:    return ~|(~v);
      3'd3:    return ~&(~v);
      3'd4:    return ^v;
      3'd5:    return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  // Structural form: every gate is a 2-input NAND. AND, OR and XOR are built
  // as cascaded chains from input 0 upward; the inverting ops add one NAND
  // wired as an inverter at the end of the chain.
  function automatic logic gate_eval(input logic [2:0] f, input logic [N-1:0] v);
    logic and_c;
    logic or_c;
    logic xor_c;
    logic t;
    and_c = v[0];
    or_c  = v[0];
    xor_c = v[0];
    for (int i = 1; i < N; i++) begin
      t     = nand2(and_c, v[i]);
      and_c = nand2(t, t);
      or_c  = nand2(nand2(or_c, or_c), nand2(v[i], v[i]));
      t     = nand2(xor_c, v[i]);
      xor_c = nand2(nand2(xor_c, t), nand2(v[i], t));
    end
    case (f)
      3'd0:    return nand2(and_c, and_c);
      3'd1:    return nand2(or_c, or_c);
      3'd2:    return and_c;
      3'd3:    return or_c;
      3'd4:    return xor_c;
      3'd5:    return nand2(xor_c, xor_c);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t          state_q,    state_d;
  logic [2:0]      op_q,       op_d;
  logic            fault_en_q, fault_en_d;
  logic [N-1:0]    fault_idx_q, fault_idx_d;
  logic            busy_q,     busy_d;
  logic            valid_q,    valid_d;
  logic [N-1:0]    minterm_q,  minterm_d;
  logic [N-1:0]    vec_q,      vec_d;
  logic            ref_bit_q,  ref_bit_d;
  logic            gate_bit_q, gate_bit_d;
  logic [TW-1:0]   tt_q,       tt_d;
  logic [N:0]      mism_cnt_q, mism_cnt_d;
  logic            done_q,     done_d;
  logic            pass_q,     pass_d;
  logic            err_q,      err_d;

  // Working values for the minterm presented next.
  logic            present;
  logic [N-1:0]    next_m;
  logic [2:0]      eval_op;
  logic            eval_fen;
  logic [N-1:0]    eval_fidx;
  logic [TW-1:0]   tt_base;
  logic [N:0]      cnt_base;
  logic            r_bit;
  logic            g_bit;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    fault_en_d  = fault_en_q;
    fault_idx_d = fault_idx_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    minterm_d   = minterm_q;
    vec_d       = vec_q;
    ref_bit_d   = ref_bit_q;
    gate_bit_d  = gate_bit_q;
    tt_d        = tt_q;
    mism_cnt_d  = mism_cnt_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = 1'b0;

    present     = 1'b0;
    next_m      = minterm_q + 1'b1;
    eval_op     = op_q;
    eval_fen    = fault_en_q;
    eval_fidx   = fault_idx_q;
    tt_base     = tt_q;
    cnt_base    = mism_cnt_q;
    r_bit       = 1'b0;
    g_bit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (op <= 3'd5) begin
            // Latch the configuration and present minterm 0 on the same
            // edge, evaluated from the live inputs being latched.
            state_d     = S_SWEEP;
            busy_d      = 1'b1;
            op_d        = op;
            fault_en_d  = fault_en;
            fault_idx_d = fault_idx;
            pass_d      = 1'b0;
            present     = 1'b1;
            next_m      = '0;
            eval_op     = op;
            eval_fen    = fault_en;
            eval_fidx   = fault_idx;
            tt_base     = '0;
            cnt_base    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SWEEP: begin
        if (minterm_q == LAST_M) begin
          // Counter holds at TW-1 here; it only restarts at 0 on a new start.
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (mism_cnt_q == '0);
        end else begin
          present = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (present) begin
      r_bit          = ref_eval(eval_op, next_m);
      g_bit          = gate_eval(eval_op, next_m) ^ (eval_fen && (next_m == eval_fidx));
      valid_d        = 1'b1;
      minterm_d      = next_m;
      vec_d          = next_m;
      ref_bit_d      = r_bit;
      gate_bit_d     = g_bit;
      tt_d           = tt_base;
      tt_d[next_m]   = r_bit;
      mism_cnt_d     = cnt_base + (N+1)'(r_bit != g_bit);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      fault_en_q  <= 1'b0;
      fault_idx_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      minterm_q   <= '0;
      vec_q       <= '0;
      ref_bit_q   <= 1'b0;
      gate_bit_q  <= 1'b0;
      tt_q        <= '0;
      mism_cnt_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fault_en_q  <= fault_en_d;
      fault_idx_q <= fault_idx_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      minterm_q   <= minterm_d;
      vec_q       <= vec_d;
      ref_bit_q   <= ref_bit_d;
      gate_bit_q  <= gate_bit_d;
      tt_q        <= tt_d;
      mism_cnt_q  <= mism_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign minterm  = minterm_q;
  assign vec      = vec_q;
  assign ref_bit  = ref_bit_q;
  assign gate_bit = gate_bit_q;
  assign tt       = tt_q;
  assign mism_cnt = mism_cnt_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gate_equiv_sweeper.sv
// Directed bench for gate_equiv_sweeper: one instance with N=2 and one with
// N=4 share clock and reset. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, i.e. after the edge has settled.

module tb_gate_equiv_sweeper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // N = 2 instance
  logic        s2_start, s2_fen;
  logic [2:0]  s2_op;
  logic [1:0]  s2_fidx;
  logic        s2_busy, s2_valid, s2_ref, s2_gate, s2_done, s2_pass, s2_err;
  logic [1:0]  s2_minterm, s2_vec;
  logic [3:0]  s2_tt;
  logic [2:0]  s2_mism;

  // N = 4 instance
  logic        s4_start, s4_fen;
  logic [2:0]  s4_op;
  logic [3:0]  s4_fidx;
  logic        s4_busy, s4_valid, s4_ref, s4_gate, s4_done, s4_pass, s4_err;
  logic [3:0]  s4_minterm, s4_vec;
  logic [15:0] s4_tt;
  logic [4:0]  s4_mism;

  gate_equiv_sweeper #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .op(s2_op),
    .fault_en(s2_fen), .fault_idx(s2_fidx), .busy(s2_busy), .valid(s2_valid),
    .minterm(s2_minterm), .vec(s2_vec), .ref_bit(s2_ref), .gate_bit(s2_gate),
    .tt(s2_tt), .mism_cnt(s2_mism), .done(s2_done), .pass(s2_pass), .err(s2_err)
  );

  gate_equiv_sweeper #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .op(s4_op),
    .fault_en(s4_fen), .fault_idx(s4_fidx), .busy(s4_busy), .valid(s4_valid),
    .minterm(s4_minterm), .vec(s4_vec), .ref_bit(s4_ref), .gate_bit(s4_gate),
    .tt(s4_tt), .mism_cnt(s4_mism), .done(s4_done), .pass(s4_pass), .err(s4_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({s2_busy, s2_valid, s2_minterm, s2_vec, s2_ref, s2_gate, s2_tt, s2_mism,
         s2_done, s2_pass, s2_err} !== '0) begin
      $display("FAIL reset_n2 outputs not zero: tt=%h mism=%0d busy=%b pass=%b",
               s2_tt, s2_mism, s2_busy, s2_pass);
      bad++;
    end
    total++;
    if ({s4_busy, s4_valid, s4_minterm, s4_vec, s4_ref, s4_gate, s4_tt, s4_mism,
         s4_done, s4_pass, s4_err} !== '0) begin
      $display("FAIL reset_n4 outputs not zero: tt=%h mism=%0d busy=%b pass=%b",
               s4_tt, s4_mism, s4_busy, s4_pass);
      bad++;
    end
  endtask

  // N=2 NAND sweep, optionally with the fault at minterm 3.
  task automatic test_nand2(input logic fen, input string name);
    logic [3:0] exp_ref;
    logic [2:0] exp_cnt;
    exp_ref  = 4'b0111;
    exp_cnt  = 3'd0;
    s2_op    = 3'd0;
    s2_fen   = fen;
    s2_fidx  = 2'd3;
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    s2_fen   = 1'b0;   // live change must not affect the latched value
    for (int m = 0; m < 4; m++) begin
      logic [1:0] mm;
      logic       eg;
      mm = m[1:0];
      eg = exp_ref[m] ^ (fen && m == 3);
      if (fen && m == 3) exp_cnt = 3'd1;
      total++;
      if ({s2_valid, s2_busy, s2_done, s2_minterm, s2_vec, s2_ref, s2_gate, s2_mism} !==
          {1'b1, 1'b1, 1'b0, mm, mm, exp_ref[m], eg, exp_cnt}) begin
        $display("FAIL %s m=%0d got v=%b b=%b d=%b m=%0d vec=%0d r=%b g=%b cnt=%0d want r=%b g=%b cnt=%0d",
                 name, m, s2_valid, s2_busy, s2_done, s2_minterm, s2_vec, s2_ref, s2_gate,
                 s2_mism, exp_ref[m], eg, exp_cnt);
        bad++;
      end
      tick();
    end
    total++;
    if ({s2_done, s2_valid, s2_busy, s2_pass, s2_tt, s2_mism} !==
        {1'b1, 1'b0, 1'b1, !fen, 4'b0111, exp_cnt}) begin
      $display("FAIL %s_done got d=%b v=%b b=%b p=%b tt=%b cnt=%0d want p=%b tt=0111 cnt=%0d",
               name, s2_done, s2_valid, s2_busy, s2_pass, s2_tt, s2_mism, !fen, exp_cnt);
      bad++;
    end
    tick();
    total++;
    if ({s2_done, s2_valid, s2_busy, s2_pass, s2_tt, s2_mism} !==
        {1'b0, 1'b0, 1'b0, !fen, 4'b0111, exp_cnt}) begin
      $display("FAIL %s_idle got d=%b v=%b b=%b p=%b tt=%b cnt=%0d want p=%b",
               name, s2_done, s2_valid, s2_busy, s2_pass, s2_tt, s2_mism, !fen);
      bad++;
    end
  endtask

  // Runs after the faulty sweep: tt=0111, mism_cnt=1 must be preserved.
  task automatic test_illegal_op();
    s2_op    = 3'd6;
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    total++;
    if ({s2_err, s2_busy, s2_valid, s2_tt, s2_mism} !== {1'b1, 1'b0, 1'b0, 4'b0111, 3'd1}) begin
      $display("FAIL illegal_op got err=%b busy=%b valid=%b tt=%b cnt=%0d want err=1 busy=0 tt=0111 cnt=1",
               s2_err, s2_busy, s2_valid, s2_tt, s2_mism);
      bad++;
    end
    tick();
    total++;
    if ({s2_err, s2_busy} !== 2'b00) begin
      $display("FAIL illegal_op_pulse got err=%b busy=%b want 0 0", s2_err, s2_busy);
      bad++;
    end
  endtask

  task automatic test_sweep4(input logic [2:0] op, input logic [15:0] exp_tt, input string name);
    s4_op    = op;
    s4_fen   = 1'b0;
    s4_fidx  = 4'd0;
    s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    for (int m = 0; m < 16; m++) begin
      logic [3:0] mm;
      mm = m[3:0];
      total++;
      if ({s4_valid, s4_busy, s4_minterm, s4_vec, s4_ref, s4_gate, s4_mism, s4_tt[m]} !==
          {1'b1, 1'b1, mm, mm, exp_tt[m], exp_tt[m], 5'd0, exp_tt[m]}) begin
        $display("FAIL %s m=%0d got v=%b m=%0d vec=%0d r=%b g=%b cnt=%0d tt=%h want r=g=%b cnt=0",
                 name, m, s4_valid, s4_minterm, s4_vec, s4_ref, s4_gate, s4_mism, s4_tt, exp_tt[m]);
        bad++;
      end
      tick();
    end
    total++;
    if ({s4_done, s4_valid, s4_busy, s4_pass, s4_tt, s4_mism} !==
        {1'b1, 1'b0, 1'b1, 1'b1, exp_tt, 5'd0}) begin
      $display("FAIL %s_done got d=%b v=%b b=%b p=%b tt=%h cnt=%0d want tt=%h cnt=0 pass=1",
               name, s4_done, s4_valid, s4_busy, s4_pass, s4_tt, s4_mism, exp_tt);
      bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    s2_op    = 3'd0;
    s2_fen   = 1'b0;
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    tick();
    tick();
    total++;
    if (s2_minterm !== 2'd2) begin
      $display("FAIL reset_mid_pos got m=%0d want 2", s2_minterm);
      bad++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({s2_busy, s2_valid, s2_minterm, s2_vec, s2_ref, s2_gate, s2_tt, s2_mism,
         s2_done, s2_pass, s2_err} !== '0) begin
      $display("FAIL reset_mid_clear got busy=%b valid=%b m=%0d tt=%b cnt=%0d",
               s2_busy, s2_valid, s2_minterm, s2_tt, s2_mism);
      bad++;
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s2_done || s2_valid || s2_busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      $display("FAIL reset_mid_quiet got active_cycles=%0d want 0", dones);
      bad++;
    end
  endtask

  // NOR sweep with start re-pulsed and op changed mid-sweep.
  task automatic test_busy_ignore();
    int dones, valids;
    logic [15:0] tt_at_done;
    tt_at_done = 16'hxxxx;
    s4_op    = 3'd1;
    s4_start = 1'b1;
    tick();
    s4_op    = 3'd4;
    s4_fen   = 1'b1;
    s4_fidx  = 4'd5;
    dones  = 1'b0;
    valids = 0;
    for (int i = 0; i < 30; i++) begin
      s4_start = (i < 4) || (i == 8);
      if (s4_valid) valids++;
      if (s4_done) begin
        dones++;
        tt_at_done = s4_tt;
      end
      tick();
    end
    s4_start = 1'b0;
    s4_fen   = 1'b0;
    total++;
    if (dones !== 1 || valids !== 16) begin
      $display("FAIL busy_ignore_count got dones=%0d valids=%0d want 1 16", dones, valids);
      bad++;
    end
    total++;
    if (tt_at_done !== 16'h0001 || s4_mism !== 5'd0 || s4_pass !== 1'b1 || s4_err !== 1'b0) begin
      $display("FAIL busy_ignore_result got tt=%h cnt=%0d pass=%b want tt=0001 cnt=0 pass=1",
               tt_at_done, s4_mism, s4_pass);
      bad++;
    end
  endtask

  // start held high through DONE: restart one cycle after returning to idle.
  task automatic test_back_to_back();
    logic seen;
    s2_op    = 3'd2;
    s2_fen   = 1'b0;
    s2_start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    total++;
    if ({s2_done, s2_busy, s2_tt, s2_pass} !== {1'b1, 1'b1, 4'b1000, 1'b1}) begin
      $display("FAIL b2b_done got d=%b b=%b tt=%b p=%b want 1 1 1000 1",
               s2_done, s2_busy, s2_tt, s2_pass);
      bad++;
    end
    tick();
    total++;
    if ({s2_busy, s2_valid, s2_done} !== 3'b000) begin
      $display("FAIL b2b_idle got b=%b v=%b d=%b want 000", s2_busy, s2_valid, s2_done);
      bad++;
    end
    tick();
    s2_start = 1'b0;
    total++;
    if ({s2_busy, s2_valid, s2_minterm, s2_tt, s2_pass} !== {1'b1, 1'b1, 2'd0, 4'b0000, 1'b0}) begin
      $display("FAIL b2b_restart got b=%b v=%b m=%0d tt=%b p=%b want 1 1 0 0000 0",
               s2_busy, s2_valid, s2_minterm, s2_tt, s2_pass);
      bad++;
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = s2_done;
    end
    total++;
    if (!seen || s2_tt !== 4'b1000) begin
      $display("FAIL b2b_second_done got seen=%b tt=%b want 1 1000", seen, s2_tt);
      bad++;
    end
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    s2_start = 1'b0; s2_op = 3'd0; s2_fen = 1'b0; s2_fidx = 2'd0;
    s4_start = 1'b0; s4_op = 3'd0; s4_fen = 1'b0; s4_fidx = 4'd0;
    #1;
    test_reset();
    test_nand2(1'b0, "nand2");
    test_nand2(1'b1, "nand2_fault");
    test_illegal_op();
    test_sweep4(3'd4, 16'h6996, "xor4");
    test_sweep4(3'd1, 16'h0001, "nor4");
    test_sweep4(3'd0, 16'h7FFF, "nand4");
    test_sweep4(3'd2, 16'h8000, "and4");
    test_sweep4(3'd3, 16'hFFFE, "or4");
    test_sweep4(3'd5, 16'h9669, "xnor4");
    test_reset_mid_sweep();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
